// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and byte accessor for the UART frame unpacker.
package uart_frame_pkg;

   localparam int unsigned FRAME_BYTES = 108;
   localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
   localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);
   localparam int unsigned FRAME_W     = FRAME_BYTES * 8;

   // Index value once every frame byte has been folded into the checksum
   localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(FRAME_BYTES);
   // Index of the final payload byte; the trailer after it is never streamed
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 2);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      VERIFY,
      STREAM
   } unpack_state_t;

   // Byte 0 (first received) sits in the MSBs of the frame vector
   function automatic logic [7:0] byte_at(input logic [FRAME_W-1:0] frame,
                                          input logic [IDX_W-1:0]   k);
      return frame[FRAME_W - 8 - 8 * 32'(k) +: 8];
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and rollover to 1 after rollover_val.
module flex_counter #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    i_clear,
   input  logic                    i_count_enable,
   input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
   output logic [NUM_CNT_BITS-1:0] o_count
);

   logic [NUM_CNT_BITS-1:0] r_count;
   logic [NUM_CNT_BITS-1:0] w_count_next;

   // Next count: clear wins, otherwise increment with rollover back to 1
   always_comb begin
      w_count_next = r_count;
      if (i_clear) begin
         w_count_next = '0;
      end else if (i_count_enable) begin
         if (r_count == i_rollover_val) begin
            w_count_next = NUM_CNT_BITS'(1);
         end else begin
            w_count_next = r_count + NUM_CNT_BITS'(1);
         end
      end
   end

   // Count register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/uart_frame_unpacker.sv
// Captures a received UART frame, validates it and streams its payload bytes
// over a valid/ready interface.
// Build option: define UART_UNPACK_CHECKSUM_EN to add the full XOR checksum pass
// (CHECK state); without it a single VERIFY cycle tests only the sync byte.
module uart_frame_unpacker
   import uart_frame_pkg::*;
(
   input  logic               clk,
   input  logic               n_rst,
   input  logic [FRAME_W-1:0] rx_data,
   input  logic               data_ready,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               frame_error,
   output logic               overrun,
   output logic               busy
);

   unpack_state_t      r_state, w_state_next;
   logic [FRAME_W-1:0] r_frame;
   logic [IDX_W-1:0]   w_idx;
   logic [IDX_W-1:0]   w_idx_inc;
   logic               w_cnt_clear;
   logic               w_cnt_en;
   logic               w_sync_ok;

   logic [7:0]         r_out_data, w_out_data_next;
   logic               r_out_valid, w_out_valid_next;
   logic               r_out_last, w_out_last_next;
   logic               r_frame_error, w_frame_error_next;
   logic               r_overrun;

`ifdef UART_UNPACK_CHECKSUM_EN
   logic [7:0]         r_acc, w_acc_next;
`endif

   // Rollover at IDX_END lets the post-check increment land the index on byte 1
   flex_counter #(
      .NUM_CNT_BITS (IDX_W)
   ) u_idx_cnt (
      .clk            (clk),
      .n_rst          (n_rst),
      .i_clear        (w_cnt_clear),
      .i_count_enable (w_cnt_en),
      .i_rollover_val (IDX_END),
      .o_count        (w_idx)
   );

   assign w_idx_inc = w_idx + IDX_W'(1);
   assign w_sync_ok = (byte_at(r_frame, '0) == SYNC_BYTE);

   // Next-state, index control and registered-output next values
   always_comb begin
      w_state_next       = r_state;
      w_cnt_clear        = 1'b0;
      w_cnt_en           = 1'b0;
      w_out_data_next    = r_out_data;
      w_out_valid_next   = r_out_valid;
      w_out_last_next    = r_out_last;
      w_frame_error_next = 1'b0;
`ifdef UART_UNPACK_CHECKSUM_EN
      w_acc_next         = r_acc;
`endif

      case (r_state)
         IDLE: begin
            if (data_ready) begin
               w_cnt_clear  = 1'b1;
`ifdef UART_UNPACK_CHECKSUM_EN
               w_acc_next   = '0;
               w_state_next = CHECK;
`else
               w_state_next = VERIFY;
`endif
            end
         end

`ifdef UART_UNPACK_CHECKSUM_EN
         CHECK: begin
            if (w_idx == IDX_END) begin
               // All bytes folded in; a good frame XORs to zero including the trailer
               if (w_sync_ok && (r_acc == 8'h00)) begin
                  w_cnt_en     = 1'b1;
                  w_state_next = STREAM;
               end else begin
                  w_frame_error_next = 1'b1;
                  w_state_next       = IDLE;
               end
            end else begin
               w_acc_next = r_acc ^ byte_at(r_frame, w_idx);
               w_cnt_en   = 1'b1;
            end
         end
`else
         VERIFY: begin
            if (w_sync_ok) begin
               w_cnt_en     = 1'b1;
               w_state_next = STREAM;
            end else begin
               w_frame_error_next = 1'b1;
               w_state_next       = IDLE;
            end
         end
`endif

         STREAM: begin
            if (!r_out_valid) begin
               // First cycle in STREAM: present byte 1
               w_out_data_next  = byte_at(r_frame, w_idx);
               w_out_valid_next = 1'b1;
               w_out_last_next  = (w_idx == IDX_LAST);
            end else if (out_ready) begin
               if (r_out_last) begin
                  w_out_data_next  = '0;
                  w_out_valid_next = 1'b0;
                  w_out_last_next  = 1'b0;
                  w_state_next     = IDLE;
               end else begin
                  w_cnt_en         = 1'b1;
                  w_out_data_next  = byte_at(r_frame, w_idx_inc);
                  w_out_last_next  = (w_idx_inc == IDX_LAST);
               end
            end
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // State and registered outputs; overrun flags any frame offered while busy
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state       <= IDLE;
         r_out_data    <= '0;
         r_out_valid   <= 1'b0;
         r_out_last    <= 1'b0;
         r_frame_error <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_out_data    <= w_out_data_next;
         r_out_valid   <= w_out_valid_next;
         r_out_last    <= w_out_last_next;
         r_frame_error <= w_frame_error_next;
         r_overrun     <= data_ready && (r_state != IDLE);
      end
   end

   // Frame capture, only accepted while idle
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_frame <= '0;
      end else if ((r_state == IDLE) && data_ready) begin
         r_frame <= rx_data;
      end
   end

`ifdef UART_UNPACK_CHECKSUM_EN
   // Running XOR of frame bytes
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_acc <= '0;
      end else begin
         r_acc <= w_acc_next;
      end
   end
`endif

   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign out_last    = r_out_last;
   assign frame_error = r_frame_error;
   assign overrun     = r_overrun;
   assign busy        = (r_state != IDLE);

endmodule
